// File: rtl/input_conditioner.sv
// Input conditioner for raw pushbuttons and toggle switches.
// Synchronizes every raw bit, debounces it against a shared sample tick,
// produces registered press/release/change pulses, and stretches a CPU
// reset request while key 0 is held and for a fixed number of ticks afterwards.
module input_conditioner #(
    parameter int unsigned TICK_CYCLES      = 50000,
    parameter int unsigned STABLE_TICKS     = 8,
    parameter int unsigned RESET_HOLD_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic [9:0] sw,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [9:0] sw_level,
    output logic       sw_change,
    output logic       cpu_reset
);

    localparam int NumIn = 14;

    localparam int unsigned PreW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned CntW  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam int unsigned HoldW = (RESET_HOLD_TICKS > 0) ? $clog2(RESET_HOLD_TICKS + 1) : 1;

    localparam logic [PreW-1:0]  PreMax   = PreW'(TICK_CYCLES - 1);
    localparam logic [CntW-1:0]  CntMax   = CntW'(STABLE_TICKS - 1);
    localparam logic [HoldW-1:0] HoldInit = HoldW'(RESET_HOLD_TICKS);

    // Synchronizer flops; reset values are the idle (released / off) levels
    logic [3:0] key_meta_q;
    logic [3:0] key_sync_q;
    logic [9:0] sw_meta_q;
    logic [9:0] sw_sync_q;

    // Two-flop synchronizers for all raw inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Bits [3:0] are keys (inverted to active-high), bits [13:4] are switches
    logic [NumIn-1:0] in_sync;
    assign in_sync = {sw_sync_q, ~key_sync_q};

    logic [PreW-1:0] pre_q;
    logic [PreW-1:0] pre_d;
    logic            tick;

    // Shared prescaler: tick marks the last count before wrapping
    always_comb begin
        tick  = (pre_q == PreMax);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    logic [NumIn-1:0][CntW-1:0] cnt_q;
    logic [NumIn-1:0][CntW-1:0] cnt_d;
    logic [NumIn-1:0]           level_q;
    logic [NumIn-1:0]           level_d;

    // Per-input stability counters; any return to the current level clears the count
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < NumIn; i++) begin
            if (in_sync[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CntMax) begin
                    level_d[i] = in_sync[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic [HoldW-1:0] hold_q;
    logic [HoldW-1:0] hold_d;

    // Hold counter reloads while key 0 is down and drains one step per tick after release
    always_comb begin
        if (level_q[0]) begin
            hold_d = HoldInit;
        end else if (tick && (hold_q != '0)) begin
            hold_d = hold_q - 1'b1;
        end else begin
            hold_d = hold_q;
        end
    end

    logic [3:0] press_q;
    logic [3:0] release_q;
    logic       sw_change_q;
    logic       cpu_reset_q;

    // State and registered outputs; pulses are derived from next vs current level so
    // they coincide with the first cycle the new level is visible
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q       <= '0;
            cnt_q       <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            sw_change_q <= 1'b0;
            hold_q      <= HoldInit;
            cpu_reset_q <= 1'b1;
        end else begin
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            press_q     <= level_d[3:0] & ~level_q[3:0];
            release_q   <= ~level_d[3:0] & level_q[3:0];
            sw_change_q <= |(level_d[13:4] ^ level_q[13:4]);
            hold_q      <= hold_d;
            cpu_reset_q <= (hold_d != '0) || level_d[0];
        end
    end

    assign key_level   = level_q[3:0];
    assign sw_level    = level_q[13:4];
    assign key_press   = press_q;
    assign key_release = release_q;
    assign sw_change   = sw_change_q;
    assign cpu_reset   = cpu_reset_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios followed by random
// input toggling, compared every cycle against a tick-counting reference model.
module tb_input_conditioner;

    localparam int T = 4;
    localparam int S = 3;
    localparam int H = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [9:0] sw    = 10'h000;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [9:0] sw_level;
    logic       sw_change;
    logic       cpu_reset;

    always #5 clk = ~clk;

    input_conditioner #(
        .TICK_CYCLES     (T),
        .STABLE_TICKS    (S),
        .RESET_HOLD_TICKS(H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .sw         (sw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .sw_level   (sw_level),
        .sw_change  (sw_change),
        .cpu_reset  (cpu_reset)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Pulse and hold observations
    int press_cnt [4];
    int rel_cnt   [4];
    int swch_cnt;
    int hold_cyc;

    // Reference model: edge k counts rising clock edges since reset release;
    // tick falls on every edge where k is a multiple of T.
    int         k;
    logic [13:0] m1;
    logic [13:0] m2;
    logic [13:0] e_lvl;
    int         since [14];
    int         load_edge;
    logic [3:0] e_press;
    logic [3:0] e_rel;
    logic       e_swch;
    logic       e_cpu;

    // Number of tick edges in the inclusive edge range [a, b], a >= 1
    function automatic int ticks_in(input int a, input int b);
        if (b < a) return 0;
        return b / T - (a - 1) / T;
    endfunction

    task automatic model_step();
        logic [13:0] synced;
        logic [13:0] old;
        if (reset) begin
            k         = 0;
            m1        = 14'h0;
            m2        = 14'h0;
            e_lvl     = 14'h0;
            foreach (since[i]) since[i] = 0;
            load_edge = 0;
            e_press   = 4'h0;
            e_rel     = 4'h0;
            e_swch    = 1'b0;
            e_cpu     = 1'b1;
        end else begin
            k      = k + 1;
            synced = m2;
            m2     = m1;
            m1     = {sw, ~key_n};
            old    = e_lvl;
            for (int i = 0; i < 14; i++) begin
                if (synced[i] == e_lvl[i]) begin
                    since[i] = 0;
                end else begin
                    if (since[i] == 0) since[i] = k;
                    // Flip once the differing value has spanned S ticks without a break
                    if ((k % T == 0) && (ticks_in(since[i], k) >= S)) begin
                        e_lvl[i] = synced[i];
                        since[i] = 0;
                    end
                end
            end
            if (old[0]) load_edge = k;
            e_press = e_lvl[3:0] & ~old[3:0];
            e_rel   = ~e_lvl[3:0] & old[3:0];
            e_swch  = |(e_lvl[13:4] ^ old[13:4]);
            e_cpu   = e_lvl[0] || (ticks_in(load_edge + 1, k) < H);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
        swch_cnt = 0;
        hold_cyc = 0;
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("key_level", 16'(key_level), 16'(e_lvl[3:0]));
        chk("sw_level", 16'(sw_level), 16'(e_lvl[13:4]));
        chk("key_press", 16'(key_press), 16'(e_press));
        chk("key_release", 16'(key_release), 16'(e_rel));
        chk("sw_change", 16'(sw_change), 16'(e_swch));
        chk("cpu_reset", 16'(cpu_reset), 16'(e_cpu));
        for (int i = 0; i < 4; i++) begin
            if (key_press[i]) press_cnt[i]++;
            if (key_release[i]) rel_cnt[i]++;
        end
        if (sw_change) swch_cnt++;
        if (cpu_reset && !key_level[0]) hold_cyc++;
    endtask

    task automatic rst_vals(input string tag);
        chk({tag, "_key_level"}, 16'(key_level), 16'h0);
        chk({tag, "_key_press"}, 16'(key_press), 16'h0);
        chk({tag, "_key_release"}, 16'(key_release), 16'h0);
        chk({tag, "_sw_level"}, 16'(sw_level), 16'h0);
        chk({tag, "_sw_change"}, 16'(sw_change), 16'h0);
        chk({tag, "_cpu_reset"}, 16'(cpu_reset), 16'h1);
    endtask

    initial begin
        int found;
        int b;
        clr_counts();

        // Reset state
        repeat (2) step();
        rst_vals("in_reset");
        reset = 1'b0;

        // Idle release: hold drains on the 2nd tick (edge 8)
        repeat (7) step();
        chk("hold_before_2nd_tick", 16'(cpu_reset), 16'h1);
        step();
        chk("hold_after_2nd_tick", 16'(cpu_reset), 16'h0);
        chk("idle_no_pulses", 16'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]
                                  + rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]
                                  + swch_cnt), 16'h0);

        // Key 2 press: raw at edge 9, synced at 11, flips on tick at edge 20
        key_n[2] = 1'b0;
        repeat (11) step();
        chk("k2_not_yet", 16'(key_level[2]), 16'h0);
        step();
        chk("k2_level_up", 16'(key_level[2]), 16'h1);
        chk("k2_press_pulse", 16'(key_press[2]), 16'h1);
        key_n[2] = 1'b1;
        step();
        chk("k2_press_one_cycle", 16'(key_press[2]), 16'h0);
        repeat (10) step();
        chk("k2_still_held", 16'(key_level[2]), 16'h1);
        step();
        chk("k2_level_down", 16'(key_level[2]), 16'h0);
        chk("k2_release_pulse", 16'(key_release[2]), 16'h1);
        step();
        chk("k2_release_one_cycle", 16'(key_release[2]), 16'h0);
        chk("k2_press_count", 16'(press_cnt[2]), 16'h1);
        chk("k2_release_count", 16'(rel_cnt[2]), 16'h1);

        // Key 1 glitches spanning two ticks, twice; neither may register
        clr_counts();
        for (int g = 0; g < 2; g++) begin
            key_n[1] = 1'b0;
            repeat (8) step();
            key_n[1] = 1'b1;
            repeat (12) step();
        end
        chk("k1_glitch_level", 16'(key_level[1]), 16'h0);
        chk("k1_glitch_no_press", 16'(press_cnt[1]), 16'h0);

        // All switches on in one cycle
        clr_counts();
        sw    = 10'h3FF;
        found = 0;
        for (int n = 0; n < 40 && found == 0; n++) begin
            step();
            if (sw_level != 10'h000) found = 1;
        end
        chk("sw_seen", 16'(found), 16'h1);
        chk("sw_all_at_once", 16'(sw_level), 16'h3FF);
        chk("sw_change_with_level", 16'(sw_change), 16'h1);
        repeat (4) step();
        chk("sw_change_single", 16'(swch_cnt), 16'h1);

        // Key 0 held for 5 ticks: cpu_reset stays high 2 ticks past the debounced release
        clr_counts();
        key_n[0] = 1'b0;
        repeat (5 * T) step();
        key_n[0] = 1'b1;
        repeat (60) step();
        chk("k0_press_count", 16'(press_cnt[0]), 16'h1);
        chk("k0_release_count", 16'(rel_cnt[0]), 16'h1);
        chk("k0_hold_cycles", 16'(hold_cyc), 16'(H * T));
        chk("k0_cpu_reset_done", 16'(cpu_reset), 16'h0);

        // Reset in the middle of a key 3 debounce
        clr_counts();
        key_n[3] = 1'b0;
        repeat (8) step();
        reset = 1'b1;
        #1;
        rst_vals("mid_rst");
        repeat (2) step();
        reset = 1'b0;
        chk("k3_no_press_across_reset", 16'(press_cnt[3]), 16'h0);
        repeat (11) step();
        chk("k3_restart_not_yet", 16'(key_level[3]), 16'h0);
        step();
        chk("k3_restart_level", 16'(key_level[3]), 16'h1);
        chk("k3_restart_press", 16'(key_press[3]), 16'h1);
        chk("k3_press_count", 16'(press_cnt[3]), 16'h1);

        // Random toggling of single bits, occasionally a burst on the switches
        for (int n = 0; n < 900; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                b = $urandom_range(0, 13);
                if (b < 4) key_n[b] = ~key_n[b];
                else sw[b-4] = ~sw[b-4];
            end
            if ($urandom_range(0, 99) == 0) sw = 10'($urandom_range(0, 1023));
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000, meaning clk cycles per debounce sample tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter STABLE_TICKS, default 8, meaning consecutive ticks an input must hold its new value before the debounced level changes.
REQ-003 SHALL have parameter RESET_HOLD_TICKS, default 16, meaning ticks cpu_reset stays high after its cause ends.
REQ-004 SHALL have port clk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port key_n, input, 4 bits, raw asynchronous pushbuttons, active-low.
REQ-007 SHALL have port sw, input, 10 bits, raw asynchronous toggle switches.
REQ-008 SHALL have port key_level, output, 4 bits, debounced buttons, 1 = pressed.
REQ-009 SHALL have port key_press, output, 4 bits, one-cycle pulse per bit on a debounced press.
REQ-010 SHALL have port key_release, output, 4 bits, one-cycle pulse per bit on a debounced release.
REQ-011 SHALL have port sw_level, output, 10 bits, debounced switch levels.
REQ-012 SHALL have port sw_change, output, 1 bit, one-cycle pulse when any sw_level bit changes.
REQ-013 SHALL have port cpu_reset, output, 1 bit, active-high stretched reset request for the CPU subsystem.

Function
REQ-014 Every raw input bit SHALL pass through a two-flop synchronizer; key_n bits SHALL be inverted after synchronizing, giving an active-high pressed signal.
REQ-015 A shared prescaler SHALL count 0..TICK_CYCLES-1 and wrap to 0; tick SHALL be high for exactly the one cycle in which the count equals TICK_CYCLES-1.
REQ-016 Each of the 14 inputs SHALL have a stability counter wide enough to hold STABLE_TICKS-1.
REQ-017 Counter behaviour: synced value equal to debounced level -> clear counter to 0, regardless of tick.
REQ-018 Counter behaviour: synced value differs and tick high with counter < STABLE_TICKS-1 -> increment the counter.
REQ-019 Counter behaviour: synced value differs and tick high with counter = STABLE_TICKS-1 -> on that clock edge, load the debounced level with the synced value and clear the counter.
REQ-020 A glitch shorter than STABLE_TICKS ticks SHALL leave the level unchanged, since a return to the old value clears the counter.
REQ-021 key_press[i] SHALL be high in exactly the cycle where key_level[i] first reads 1; key_release[i] SHALL be high in exactly the cycle where key_level[i] first reads 0.
REQ-022 sw_change SHALL be high in exactly the cycle where any sw_level bit first reads its new value, as a single pulse even when several bits change together.
REQ-023 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-024 cpu_reset SHALL be driven by a hold counter, which loads RESET_HOLD_TICKS every cycle that key_level[0]=1.
REQ-025 When key_level[0]=0, the hold counter SHALL decrement on each tick until it reaches 0, then stay at 0.
REQ-026 cpu_reset SHALL be 1 while the hold counter is non-zero or key_level[0]=1, and 0 otherwise.
REQ-027 Latency: after a clean raw edge, the level change SHALL occur on the STABLE_TICKS-th tick that follows the synchronizer output changing; the synchronizer adds 2 cycles.

Reset
REQ-028 While reset is high, the synchronizer flops SHALL be forced to the idle state: key_n flops to 1, sw flops to 0.
REQ-029 While reset is high, the prescaler and all stability counters SHALL be forced to 0.
REQ-030 While reset is high, key_level, key_press, key_release, sw_level and sw_change SHALL all be 0.
REQ-031 While reset is high, the hold counter SHALL be forced to RESET_HOLD_TICKS and cpu_reset SHALL be 1.
REQ-032 A switch already on at reset release SHALL be debounced like any other edge; its sw_level goes to 1 with a sw_change pulse after STABLE_TICKS ticks.
REQ-033 Reset asserted mid-debounce SHALL discard the partial count, and no pulse SHALL be emitted.

Verification
(Bench parameters: TICK_CYCLES=4, STABLE_TICKS=3, RESET_HOLD_TICKS=2.)
REQ-034 Scenario: release reset with all inputs idle -> cpu_reset=1 until the 2nd tick after release, then 0; no pulses; all levels 0.
REQ-035 Scenario: hold key_n[2]=0 steadily -> key_level[2] rises on the 3rd tick after the synced change, with key_press[2]=1 for one cycle; releasing gives key_release[2] after 3 more ticks.
REQ-036 Scenario: key_n[1] low for 2 ticks, then high -> key_level[1] stays 0, no key_press; the stability counter returns to 0.
REQ-037 Scenario: change sw[9:0] from 0x000 to 0x3FF in one cycle -> sw_level becomes 0x3FF in a single cycle, with exactly one sw_change pulse.
REQ-038 Scenario: press key_n[0] for 5 ticks, then release -> cpu_reset high from the debounced press until 2 ticks after key_level[0] falls.
REQ-039 Scenario: assert reset midway through a key_n[3] debounce -> all outputs at reset values immediately, no key_press; after release a new full 3-tick debounce is required.
